// File: rtl/intra4x4_mode_sched_if.sv
// Scheduler-facing bundle for the intra 4x4 mode scheduler.
// The master side is the scheduler itself and the slave side is its environment.
`timescale 1ns/1ps
interface intra4x4_mode_sched_if #(
  parameter int SAD_W = 8
);
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  blk_req;
  logic [3:0]            blk_idx;
  logic                  blk_ack;
  logic [7:0]            avail_mask;
  logic                  sad_en;
  logic [7:0][SAD_W-1:0] sads;
  logic                  res_valid;
  logic                  res_ready;
  logic [3:0]            res_blk;
  logic [3:0]            res_mode;
  logic [SAD_W-1:0]      res_sad;
  logic [SAD_W+3:0]      mb_cost;

  modport master (
    input  start, abort, blk_ack, avail_mask, sads, res_ready,
    output busy, done, blk_req, blk_idx, sad_en,
           res_valid, res_blk, res_mode, res_sad, mb_cost
  );

  modport slave (
    output start, abort, blk_ack, avail_mask, sads, res_ready,
    input  busy, done, blk_req, blk_idx, sad_en,
           res_valid, res_blk, res_mode, res_sad, mb_cost
  );
endinterface

// File: rtl/intra4x4_mode_sched.sv
// Walks the 16 luma 4x4 blocks of a macroblock through the SAD unit, picks the
// cheapest allowed intra mode per block and accumulates the macroblock cost.
`timescale 1ns/1ps
module intra4x4_mode_sched #(
  parameter int SAD_W   = 8,
  parameter int SAD_LAT = 1
) (
  input logic                   clk,
  input logic                   reset,
  intra4x4_mode_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_EN, S_WAIT, S_CMP, S_OUT
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [3:0]            blk_idx_reg;
  logic [7:0]            mask_reg;
  logic [1:0]            wait_reg;
  logic [2:0]            k_reg;
  logic [7:0][SAD_W-1:0] sad_sh;
  logic [SAD_W-1:0]      best_sad_reg;
  logic [2:0]            best_idx_reg;
  logic                  best_vld_reg;
  logic [3:0]            res_mode_reg;
  logic [SAD_W-1:0]      res_sad_reg;
  logic [SAD_W+3:0]      mb_cost_reg;
  logic                  done_reg;

  logic                  wait_last;
  logic                  cap_en;
  logic                  take;
  logic [SAD_W-1:0]      cand_sad;
  logic [SAD_W-1:0]      fin_sad;
  logic [2:0]            fin_idx;
  logic                  fin_vld;
  logic                  blk_req_next;
  logic                  sad_en_next;
  logic                  res_valid_next;
  logic                  busy_next;

  // sads index order -> H.264 intra4x4 prediction mode number
  function automatic logic [3:0] mode_of(input logic [2:0] idx);
    case (idx)
      3'd0:    mode_of = 4'd0;
      3'd1:    mode_of = 4'd1;
      3'd2:    mode_of = 4'd7;
      3'd3:    mode_of = 4'd5;
      3'd4:    mode_of = 4'd8;
      3'd5:    mode_of = 4'd6;
      3'd6:    mode_of = 4'd3;
      default: mode_of = 4'd4;
    endcase
  endfunction

  assign wait_last = (wait_reg == 2'(SAD_LAT - 1));
  assign cap_en    = (state_reg == S_WAIT) && wait_last;

  // One lane per mode; each lane samples its SAD only on the capture edge.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shadow
      logic [SAD_W-1:0] lane_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          lane_reg <= '0;
        end else if (cap_en) begin
          lane_reg <= bus.sads[gi];
        end
      end
      assign sad_sh[gi] = lane_reg;
    end
  endgenerate

  // Strict less-than keeps the lower index on ties.
  assign cand_sad = sad_sh[k_reg];
  assign take     = mask_reg[k_reg] && (!best_vld_reg || (cand_sad < best_sad_reg));
  assign fin_sad  = take ? cand_sad : best_sad_reg;
  assign fin_idx  = take ? k_reg    : best_idx_reg;
  assign fin_vld  = take | best_vld_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    blk_req_next   = 1'b0;
    sad_en_next    = 1'b0;
    res_valid_next = 1'b0;
    busy_next      = (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE: begin
        if (bus.start) state_next = S_REQ;
      end
      S_REQ: begin
        blk_req_next = 1'b1;
        if (bus.blk_ack) state_next = S_EN;
      end
      S_EN: begin
        sad_en_next = 1'b1;
        state_next  = S_WAIT;
      end
      S_WAIT: begin
        if (wait_last) state_next = S_CMP;
      end
      S_CMP: begin
        if (k_reg == 3'd7) state_next = S_OUT;
      end
      S_OUT: begin
        res_valid_next = 1'b1;
        if (bus.res_ready) state_next = (blk_idx_reg == 4'd15) ? S_IDLE : S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
    // abort overrides every transition, including a same-cycle OUT handshake
    if (bus.abort && (state_reg != S_IDLE)) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_idx_reg  <= '0;
      mask_reg     <= '0;
      wait_reg     <= '0;
      k_reg        <= '0;
      best_sad_reg <= '0;
      best_idx_reg <= '0;
      best_vld_reg <= 1'b0;
      res_mode_reg <= '0;
      res_sad_reg  <= '0;
      mb_cost_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.abort && (state_reg != S_IDLE)) begin
        k_reg    <= '0;
        wait_reg <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (bus.start) begin
              blk_idx_reg <= '0;
              mb_cost_reg <= '0;
            end
          end
          S_REQ: begin
            if (bus.blk_ack) mask_reg <= bus.avail_mask;
          end
          S_WAIT: begin
            if (wait_last) begin
              wait_reg     <= '0;
              best_sad_reg <= '1;
              best_idx_reg <= '0;
              best_vld_reg <= 1'b0;
            end else begin
              wait_reg <= wait_reg + 2'd1;
            end
          end
          S_CMP: begin
            best_sad_reg <= fin_sad;
            best_idx_reg <= fin_idx;
            best_vld_reg <= fin_vld;
            k_reg        <= k_reg + 3'd1;
            if (k_reg == 3'd7) begin
              // nothing allowed: fall back to DC with a saturated cost
              res_mode_reg <= fin_vld ? mode_of(fin_idx) : 4'd2;
              res_sad_reg  <= fin_vld ? fin_sad : '1;
            end
          end
          S_OUT: begin
            if (bus.res_ready) begin
              mb_cost_reg <= mb_cost_reg + {4'd0, res_sad_reg};
              if (blk_idx_reg == 4'd15) begin
                done_reg <= 1'b1;
              end else begin
                blk_idx_reg <= blk_idx_reg + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy      = busy_next;
  assign bus.done      = done_reg;
  assign bus.blk_req   = blk_req_next;
  assign bus.blk_idx   = blk_idx_reg;
  assign bus.sad_en    = sad_en_next;
  assign bus.res_valid = res_valid_next;
  assign bus.res_blk   = blk_idx_reg;
  assign bus.res_mode  = res_mode_reg;
  assign bus.res_sad   = res_sad_reg;
  assign bus.mb_cost   = mb_cost_reg;

endmodule

// File: tb/tb_intra4x4_mode_sched.sv
// Randomized scoreboard bench for intra4x4_mode_sched: a driver plays the residual
// generator and SAD unit, a separate monitor checks every accepted result.
`timescale 1ns/1ps
module tb_intra4x4_mode_sched;
  localparam int SAD_LAT = 1;
  localparam int MODE_OF [8] = '{0, 1, 7, 5, 8, 6, 3, 4};

  typedef struct packed {
    logic [3:0] blk;
    logic [3:0] mode;
    logic [7:0] sad;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   model_cost = 0;
  int   bp_blk = -1;
  int   bp_cnt = 0;
  exp_t exp_q[$];
  logic [7:0] cur_sads [8];

  intra4x4_mode_sched_if #(.SAD_W(8)) bus ();

  intra4x4_mode_sched #(.SAD_W(8), .SAD_LAT(SAD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: lowest SAD among allowed modes, first such index wins; none -> DC.
  function automatic void ref_pick(input logic [7:0] m, output int mode, output int sad);
    int best;
    best = 256;
    for (int k = 0; k < 8; k++)
      if (m[k] && (int'(cur_sads[k]) < best)) best = int'(cur_sads[k]);
    if (best == 256) begin
      mode = 2;
      sad  = 255;
    end else begin
      mode = -1;
      for (int k = 0; k < 8; k++)
        if ((mode < 0) && m[k] && (int'(cur_sads[k]) == best)) mode = MODE_OF[k];
      sad = best;
    end
  endfunction

  task automatic gen(input int pat, output logic [7:0] m);
    case (pat)
      0: begin
        for (int k = 0; k < 8; k++) cur_sads[k] = 8'(10 + k);
        cur_sads[3] = 8'd5;
        m = 8'hFF;
      end
      1: begin
        for (int k = 0; k < 8; k++) cur_sads[k] = 8'd20;
        m = 8'hFF;
      end
      2: begin
        for (int k = 0; k < 8; k++) cur_sads[k] = 8'd20;
        m = 8'hFE;
      end
      3: begin
        for (int k = 0; k < 8; k++) cur_sads[k] = 8'($urandom_range(0, 255));
        m = 8'h00;
      end
      default: begin
        for (int k = 0; k < 8; k++)
          cur_sads[k] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(100, 103))
                                                    : 8'($urandom_range(0, 255));
        m = 8'($urandom);
      end
    endcase
  endtask

  task automatic drive_sads();
    for (int k = 0; k < 8; k++) bus.sads[k] = cur_sads[k];
  endtask

  task automatic scramble();
    for (int k = 0; k < 8; k++) bus.sads[k] = 8'($urandom);
  endtask

  // Runs one macroblock; abort_b / rst_b cut it short inside CMP of that block.
  task automatic run_mb(input int pat, input int ack_dly, input bit scr, input int bp,
                        input int abort_b, input int rst_b, input bit chk_lat);
    int n;
    int st_cyc;
    int mode;
    int sad;
    logic [7:0] m;
    bp_blk     = bp;
    bp_cnt     = 0;
    model_cost = 0;
    bus.start  = 1'b1;
    st_cyc     = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int b = 0; b < 16; b++) begin
      n = 0;
      while (!bus.blk_req && (n < 300)) begin
        @(negedge clk);
        n++;
      end
      if (!bus.blk_req) begin
        chk("blk_req_timeout", 64'(bus.blk_req), 64'd1);
        return;
      end
      chk("blk_idx", 64'(bus.blk_idx), 64'(b));
      gen(pat, m);
      repeat (ack_dly) begin
        bus.start = 1'b1;
        @(negedge clk);
      end
      bus.start = 1'b0;
      if (ack_dly > 0) chk("req_held", 64'(bus.blk_req), 64'd1);
      ref_pick(m, mode, sad);
      exp_q.push_back('{blk: 4'(b), mode: 4'(mode), sad: 8'(sad)});
      bus.blk_ack    = 1'b1;
      bus.avail_mask = m;
      if (scr) scramble(); else drive_sads();
      @(negedge clk);
      bus.blk_ack    = 1'b0;
      bus.avail_mask = 8'($urandom);
      chk("sad_en_after_ack", 64'(bus.sad_en), 64'd1);
      chk("blk_req_dropped", 64'(bus.blk_req), 64'd0);
      if (scr) scramble();
      repeat (SAD_LAT) @(negedge clk);
      chk("sad_en_one_cycle", 64'(bus.sad_en), 64'd0);
      drive_sads();
      @(negedge clk);
      if (scr) scramble();
      if (b == abort_b) begin
        @(posedge clk);
        #1 bus.abort = 1'b1;
        @(negedge clk);
        chk("busy_before_abort", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1 bus.abort = 1'b0;
        @(negedge clk);
        chk("busy_after_abort", 64'(bus.busy), 64'd0);
        void'(exp_q.pop_back());
        repeat (4) begin
          chk("no_done_after_abort", 64'({bus.done, bus.blk_req, bus.res_valid}), 64'd0);
          @(negedge clk);
        end
        return;
      end
      if (b == rst_b) begin
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs",
               64'({bus.busy, bus.done, bus.blk_req, bus.blk_idx, bus.sad_en, bus.res_valid,
                    bus.res_blk, bus.res_mode, bus.res_sad, bus.mb_cost}), 64'd0);
        @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        return;
      end
    end
    n = 0;
    while (!bus.done && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(bus.done), 64'd1);
    if (chk_lat) chk("start_to_done", 64'(cyc - st_cyc), 64'(16 * (11 + SAD_LAT)));
    chk("busy_at_done", 64'(bus.busy), 64'd0);
    chk("mb_cost_final", 64'(bus.mb_cost), 64'(model_cost));
    if (pat == 0) chk("mb_cost_80", 64'(bus.mb_cost), 64'd80);
    if (pat == 3) chk("mb_cost_4080", 64'(bus.mb_cost), 64'd4080);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("done_single_pulse", 64'(bus.done), 64'd0);
  endtask

  // Downstream: ready high except a fixed stall on the chosen block.
  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if ((bp_blk >= 0) && bus.res_valid && (int'(bus.res_blk) == bp_blk) && (bp_cnt < 5)) begin
        bus.res_ready = 1'b0;
        bp_cnt++;
      end else begin
        bus.res_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stability under stall.
  initial begin
    logic       hold_v;
    logic       chk_cost;
    logic [15:0] snap;
    exp_t       e;
    hold_v   = 1'b0;
    chk_cost = 1'b0;
    snap     = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_v   = 1'b0;
        chk_cost = 1'b0;
      end else begin
        if (chk_cost) begin
          chk("mb_cost_step", 64'(bus.mb_cost), 64'(model_cost));
          chk_cost = 1'b0;
        end
        if (bus.res_valid && !bus.res_ready) begin
          if (hold_v) chk("res_stable", 64'({bus.res_blk, bus.res_mode, bus.res_sad}), 64'(snap));
          chk("stall_blk_req", 64'(bus.blk_req), 64'd0);
          chk("stall_mb_cost", 64'(bus.mb_cost), 64'(model_cost));
          snap   = {bus.res_blk, bus.res_mode, bus.res_sad};
          hold_v = 1'b1;
        end else if (bus.res_valid && !bus.abort) begin
          hold_v = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got blk=%0d with no result expected", bus.res_blk);
          end else begin
            e = exp_q.pop_front();
            chk("res_blk", 64'(bus.res_blk), 64'(e.blk));
            chk("res_mode", 64'(bus.res_mode), 64'(e.mode));
            chk("res_sad", 64'(bus.res_sad), 64'(e.sad));
            model_cost = model_cost + int'(e.sad);
            chk_cost   = 1'b1;
            $display("result blk=%0d mode=%0d sad=%0d cost=%0d",
                     bus.res_blk, bus.res_mode, bus.res_sad, model_cost);
          end
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.blk_ack    = 1'b0;
    bus.avail_mask = 8'h00;
    for (int k = 0; k < 8; k++) bus.sads[k] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({bus.busy, bus.done, bus.blk_req, bus.blk_idx, bus.sad_en, bus.res_valid,
             bus.res_blk, bus.res_mode, bus.res_sad, bus.mb_cost}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    run_mb(0, 0, 1'b0, -1, -1, -1, 1'b1);
    run_mb(1, 0, 1'b0, -1, -1, -1, 1'b0);
    run_mb(2, 0, 1'b0, -1, -1, -1, 1'b0);
    run_mb(3, 0, 1'b0, -1, -1, -1, 1'b0);
    run_mb(4, 3, 1'b1,  3, -1, -1, 1'b0);
    run_mb(4, 0, 1'b0, -1,  7, -1, 1'b0);
    @(posedge clk);
    #1 bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    run_mb(4, 1, 1'b1, -1, -1, -1, 1'b0);
    run_mb(4, 0, 1'b0, -1, -1,  5, 1'b0);
    run_mb(0, 0, 1'b0, -1, -1, -1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
